// File: rtl/apb_pkg.sv
// Shared APB definitions for the AXI4-Lite-to-APB bridge and its completers.
package apb_pkg;

    localparam int APB_DATA_W = 32;
    localparam int APB_ADDR_W = 32;
    localparam int APB_STRB_W = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_req_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational register decode of a latched APB address.
// Optional macro APB_SLV_PPROT_EN adds the secure-register lookup.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS  = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [NUM_REGS-1:0]   RO_MASK   = '0
`ifdef APB_SLV_PPROT_EN
    ,
    parameter logic [NUM_REGS-1:0]   SECURE_MASK = '0
`endif
) (
    input  logic [APB_ADDR_W-1:0] addr,
    output logic                  hit,
    output logic [5:0]            idx,
    output logic                  ro
`ifdef APB_SLV_PPROT_EN
    ,
    output logic                  secure
`endif
);

    logic [APB_ADDR_W-1:0] off;

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        off = addr - BASE_ADDR;
        // The subtraction wraps for addresses below the base, hence the explicit guard.
        hit = (addr >= BASE_ADDR) && (off < APB_ADDR_W'(NUM_REGS * 4)) && (off[1:0] == 2'b00);
        idx = off[7:2];
        ro  = 1'b0;
`ifdef APB_SLV_PPROT_EN
        secure = 1'b0;
`endif
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 6'(i)) begin
                ro = RO_MASK[i];
`ifdef APB_SLV_PPROT_EN
                secure = SECURE_MASK[i];
`endif
            end
        end
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3/APB4 completer holding a bank of 32-bit control/status registers.
// Optional macro APB_SLV_PPROT_EN rejects non-secure accesses to SECURE_MASK registers.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                    NUM_REGS    = 16,
    parameter logic [APB_ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
`ifdef APB_SLV_PPROT_EN
    ,
    parameter logic [NUM_REGS-1:0]   SECURE_MASK = '0
`endif
) (
    input  logic                         s_apb_pclk,
    input  logic                         s_apb_preset,
    input  logic [APB_ADDR_W-1:0]        s_apb_paddr,
    input  logic                         s_apb_psel,
    input  logic                         s_apb_penable,
    input  logic                         s_apb_pwrite,
    input  logic [APB_DATA_W-1:0]        s_apb_pwdata,
    input  logic [APB_STRB_W-1:0]        s_apb_pstrb,
    input  logic [2:0]                   s_apb_pprot,
    output logic                         s_apb_pready,
    output logic [APB_DATA_W-1:0]        s_apb_prdata,
    output logic                         s_apb_pslverr,
    input  logic [NUM_REGS*32-1:0]       ro_value,
    output logic [NUM_REGS*32-1:0]       reg_out,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    state_t          state_q, state_d;
    apb_req_t        req_q;
    logic [3:0]      cnt_q;
    logic [31:0]     regs_q [NUM_REGS];
    logic [31:0]     rd_value;
    logic            hit, ro, err, setup, commit;
    logic [5:0]      idx;

`ifdef APB_SLV_PPROT_EN
    logic [2:0]      prot_q;
    logic            secure;
`else
    logic            unused_pprot;
    assign unused_pprot = ^s_apb_pprot;
`endif

    apb_addr_decode #(
        .NUM_REGS    (NUM_REGS),
        .BASE_ADDR   (BASE_ADDR),
        .RO_MASK     (RO_MASK)
`ifdef APB_SLV_PPROT_EN
        ,
        .SECURE_MASK (SECURE_MASK)
`endif
    ) u_decode (
        .addr   (req_q.addr),
        .hit    (hit),
        .idx    (idx),
        .ro     (ro)
`ifdef APB_SLV_PPROT_EN
        ,
        .secure (secure)
`endif
    );

    assign setup = s_apb_psel && !s_apb_penable;

    always_comb begin
        err = !hit || (req_q.write && ro);
`ifdef APB_SLV_PPROT_EN
        err = err || (prot_q[1] && secure);
`endif
    end

    assign commit = (state_q == ACCESS) && s_apb_psel && s_apb_penable && s_apb_pready
                    && req_q.write && !err;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge s_apb_pclk) begin
        if (s_apb_preset) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (setup) state_d = ACCESS;
            ACCESS: if (!s_apb_psel || (s_apb_penable && s_apb_pready)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_apb_pready  = 1'b0;
        s_apb_pslverr = 1'b0;
        s_apb_prdata  = '0;
        if (state_q == ACCESS && cnt_q == 4'd0) begin
            s_apb_pready  = 1'b1;
            s_apb_pslverr = err;
            if (!req_q.write && !err) s_apb_prdata = rd_value;
        end
    end

    always_comb begin
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == 6'(i)) rd_value = RO_MASK[i] ? ro_value[32*i +: 32] : regs_q[i];
        end
    end

    // NOTE: the register array is reset deliberately; reg_out must read zero straight out of reset.
    always_ff @(posedge s_apb_pclk) begin
        if (s_apb_preset) begin
            req_q    <= '0;
            cnt_q    <= '0;
            wr_pulse <= '0;
`ifdef APB_SLV_PPROT_EN
            prot_q   <= '0;
`endif
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            wr_pulse <= '0;
            if (state_q == IDLE && setup) begin
                req_q <= '{addr: s_apb_paddr, write: s_apb_pwrite,
                           wdata: s_apb_pwdata, strb: s_apb_pstrb};
                cnt_q <= 4'(WAIT_STATES);
`ifdef APB_SLV_PPROT_EN
                prot_q <= s_apb_pprot;
`endif
            end else if (state_q == ACCESS && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit && idx == 6'(i)) begin
                    wr_pulse[i] <= 1'b1;
                    for (int k = 0; k < APB_STRB_W; k++) begin
                        if (req_q.strb[k] && !RO_MASK[i]) regs_q[i][8*k +: 8] <= req_q.wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[32*g +: 32] = RO_MASK[g] ? 32'h0 : regs_q[g];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed scoreboard bench: dut0 (base 0, no waits, reg 2 read-only), dut3 (base 0x100, 3 waits).
module tb_apb_slave_regfile;
    import apb_pkg::*;

    localparam int NR = 16;

    logic            clk = 1'b0;
    logic            preset0, preset3;
    logic [31:0]     paddr, pwdata;
    logic            psel0, psel3, penable, pwrite;
    logic [3:0]      pstrb;
    logic [2:0]      pprot;
    logic [NR*32-1:0] ro_value;

    logic            pready0, pslverr0, pready3, pslverr3;
    logic [31:0]     prdata0, prdata3;
    logic [NR*32-1:0] reg_out0, reg_out3;
    logic [NR-1:0]   wr_pulse0, wr_pulse3;

    always #5 clk = ~clk;

    apb_slave_regfile #(
        .NUM_REGS(NR), .BASE_ADDR(32'h0), .WAIT_STATES(0), .RO_MASK(16'h0004)
`ifdef APB_SLV_PPROT_EN
        , .SECURE_MASK(16'h0001)
`endif
    ) dut0 (
        .s_apb_pclk(clk), .s_apb_preset(preset0), .s_apb_paddr(paddr), .s_apb_psel(psel0),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_pready(pready0),
        .s_apb_prdata(prdata0), .s_apb_pslverr(pslverr0), .ro_value(ro_value),
        .reg_out(reg_out0), .wr_pulse(wr_pulse0)
    );

    apb_slave_regfile #(
        .NUM_REGS(NR), .BASE_ADDR(32'h100), .WAIT_STATES(3), .RO_MASK(16'h0000)
`ifdef APB_SLV_PPROT_EN
        , .SECURE_MASK(16'h0000)
`endif
    ) dut3 (
        .s_apb_pclk(clk), .s_apb_preset(preset3), .s_apb_paddr(paddr), .s_apb_psel(psel3),
        .s_apb_penable(penable), .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata),
        .s_apb_pstrb(pstrb), .s_apb_pprot(pprot), .s_apb_pready(pready3),
        .s_apb_prdata(prdata3), .s_apb_pslverr(pslverr3), .ro_value(ro_value),
        .reg_out(reg_out3), .wr_pulse(wr_pulse3)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r = old;
        for (int k = 0; k < 4; k++) if (strb[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    task automatic apb_xfer(input bit on3, input string tag, input logic [31:0] addr,
                            input bit wr, input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input logic [31:0] exp_rdata,
                            input bit exp_err, input int exp_waits);
        exp_t e;
        int   waits = 0;
        bit   done  = 1'b0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.waits = exp_waits;
        sb_q.push_back(e);
        @(posedge clk); #1;
        psel0 = !on3; psel3 = on3; penable = 1'b0;
        paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (on3 ? pready3 : pready0) begin
                e = sb_q.pop_front();
                check({tag, " prdata"}, on3 ? prdata3 : prdata0, e.rdata);
                check({tag, " pslverr"}, 32'(on3 ? pslverr3 : pslverr0), 32'(e.err));
                check({tag, " wait_cycles"}, 32'(waits), 32'(e.waits));
                done = 1'b1;
            end else begin
                check({tag, " pslverr_while_waiting"}, 32'(on3 ? pslverr3 : pslverr0), 32'h0);
                waits++;
                @(posedge clk); #1;
            end
        end
        if (!done) begin
            check({tag, " pready_timeout"}, 32'(done), 32'h1);
            void'(sb_q.pop_front());
        end
        @(posedge clk); #1;
        psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
    endtask

    initial begin
        logic [31:0] reg1;
        psel0 = 0; psel3 = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
        ro_value = '0;
        ro_value[31:0]  = 32'hBAD0_BAD0;
        ro_value[95:64] = 32'h1234_5678;
        preset0 = 1; preset3 = 1;
        repeat (3) @(posedge clk);
        #1 preset0 = 0; preset3 = 0;

        @(negedge clk);
        check("rst pready", 32'(pready0), 32'h0);
        check("rst pslverr", 32'(pslverr0), 32'h0);
        check("rst prdata", prdata0, 32'h0);
        check("rst reg_out nonzero", 32'(|reg_out0), 32'h0);
        check("rst wr_pulse", 32'(wr_pulse0), 32'h0);
        check("rst dut3 pready", 32'(pready3), 32'h0);

        apb_xfer(0, "rd_reg0", 32'h00, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0, 0);

        apb_xfer(0, "wr_reg1", 32'h04, 1, 32'hDEAD_BEEF, 4'b0101, 3'b000, 32'h0, 0, 0);
        reg1 = merge(32'h0, 32'hDEAD_BEEF, 4'b0101);
        @(negedge clk);
        check("wr_reg1 reg_out", reg_out0[63:32], reg1);
        check("wr_reg1 wr_pulse", 32'(wr_pulse0), 32'h0002);
        @(negedge clk);
        check("wr_reg1 pulse_one_cycle", 32'(wr_pulse0), 32'h0);

        apb_xfer(0, "wr_reg1_hi", 32'h04, 1, 32'hCAFE_F00D, 4'b1010, 3'b000, 32'h0, 0, 0);
        reg1 = merge(reg1, 32'hCAFE_F00D, 4'b1010);
        apb_xfer(0, "rd_reg1", 32'h04, 0, 32'h0, 4'h0, 3'b000, reg1, 0, 0);

        apb_xfer(0, "wr_ro_reg2", 32'h08, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1, 0);
        @(negedge clk);
        check("wr_ro_reg2 wr_pulse", 32'(wr_pulse0), 32'h0);
        check("wr_ro_reg2 reg_out", reg_out0[95:64], 32'h0);
        apb_xfer(0, "rd_ro_reg2", 32'h08, 0, 32'h0, 4'h0, 3'b000, 32'h1234_5678, 0, 0);

        apb_xfer(0, "rd_unmapped", 32'h40, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1, 0);
        apb_xfer(0, "rd_misaligned", 32'h06, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1, 0);
        apb_xfer(0, "rd_last_reg", 32'h3C, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0, 0);

        apb_xfer(0, "wr_strb0", 32'h0C, 1, 32'hFFFF_FFFF, 4'b0000, 3'b000, 32'h0, 0, 0);
        @(negedge clk);
        check("wr_strb0 wr_pulse", 32'(wr_pulse0), 32'h0008);
        check("wr_strb0 reg_out", reg_out0[127:96], 32'h0);

        // Setup phase then psel dropped: protocol abort, nothing commits.
        @(posedge clk); #1;
        psel0 = 1; penable = 0; paddr = 32'h0C; pwrite = 1; pwdata = 32'h5555_5555; pstrb = 4'hF;
        @(posedge clk); #1;
        psel0 = 0;
        repeat (2) @(negedge clk);
        check("abort wr_pulse", 32'(wr_pulse0), 32'h0);
        check("abort reg_out", reg_out0[127:96], 32'h0);
        apb_xfer(0, "rd_after_abort", 32'h0C, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0, 0);

`ifdef APB_SLV_PPROT_EN
        apb_xfer(0, "sec_wr_nonsecure", 32'h00, 1, 32'hFFFF_FFFF, 4'hF, 3'b010, 32'h0, 1, 0);
        @(negedge clk);
        check("sec_wr wr_pulse", 32'(wr_pulse0), 32'h0);
        check("sec_wr reg_out", reg_out0[31:0], 32'h0);
`endif

        apb_xfer(1, "ws3_wr_reg2", 32'h108, 1, 32'hA5A5_A5A5, 4'hF, 3'b000, 32'h0, 0, 3);
        @(negedge clk);
        check("ws3_wr reg_out", reg_out3[95:64], 32'hA5A5_A5A5);
        check("ws3_wr wr_pulse", 32'(wr_pulse3), 32'h0004);
        apb_xfer(1, "ws3_below_base", 32'hFC, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1, 3);
        apb_xfer(1, "ws3_rd_reg2", 32'h108, 0, 32'h0, 4'h0, 3'b000, 32'hA5A5_A5A5, 0, 3);
        apb_xfer(1, "ws3_past_top", 32'h140, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1, 3);

        // Reset pulsed while a 3-wait-state write to register 0 is in ACCESS.
        @(posedge clk); #1;
        psel3 = 1; penable = 0; paddr = 32'h100; pwrite = 1; pwdata = 32'hFFFF_FFFF; pstrb = 4'hF;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        preset3 = 1;
        @(posedge clk); #1;
        preset3 = 0; psel3 = 0; penable = 0;
        @(negedge clk);
        check("midrst reg_out", reg_out3[31:0], 32'h0);
        check("midrst wr_pulse", 32'(wr_pulse3), 32'h0);
        check("midrst pready", 32'(pready3), 32'h0);
        check("midrst state", 32'(dut3.state_q), 32'(IDLE));
        check("midrst reg2 cleared", reg_out3[95:64], 32'h0);
        @(negedge clk);
        check("midrst wr_pulse later", 32'(wr_pulse3), 32'h0);
        apb_xfer(1, "ws3_rd_after_rst", 32'h100, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0, 3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
